// File: rtl/bip_fetch_unit.sv
// rtl/bip_fetch_unit.sv - BIP I instruction fetch: PC, memory req/ack fetch, valid/ready issue, sticky halt
module bip_fetch_unit #(
  parameter int                  PC_WIDTH    = 11,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   pc_enable,
  output logic                   mem_req,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PHASE,
    S_REQ,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t                 state_q, state_n;
  logic [PC_WIDTH-1:0]    pc_q, pc_n;
  logic [PC_WIDTH-1:0]    addr_q, addr_n;
  logic                   req_q, req_n;
  logic [INSTR_WIDTH-1:0] instr_q, instr_n;
  logic                   valid_q, valid_n;
  logic                   halted_q, halted_n;
  logic                   is_hlt;

  // HLT is the all-zero opcode in the top five bits of the held word
  assign is_hlt = (instr_q[INSTR_WIDTH-1 -: 5] == 5'b00000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      addr_q   <= addr_n;
      req_q    <= req_n;
      instr_q  <= instr_n;
      valid_q  <= valid_n;
      halted_q <= halted_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    pc_n     = pc_q;
    addr_n   = addr_q;
    req_n    = req_q;
    instr_n  = instr_q;
    valid_n  = valid_q;
    halted_n = halted_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_n = S_WAIT_PHASE;
      end
      S_WAIT_PHASE: begin
        if (pc_enable) begin
          state_n = S_REQ;
          req_n   = 1'b1;
          addr_n  = pc_q;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_n = S_ISSUE;
          req_n   = 1'b0;
          valid_n = 1'b1;
          instr_n = mem_data;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          valid_n = 1'b0;
          if (is_hlt) begin
            state_n  = S_HALTED;
            halted_n = 1'b1;
          end else begin
            // a fresh phase strobe is required for every fetch, so go back to waiting
            state_n = S_WAIT_PHASE;
            pc_n    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      S_HALTED: begin
        state_n = S_HALTED;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule
